// File: rtl/conv_pkg.sv
// Shared types and sizing for the 3x3 convolution window scheduler.
package conv_pkg;

    localparam int unsigned DEFAULT_PIX_W = 8;
    localparam int unsigned KSIZE         = 3;
    localparam int unsigned WIN_W         = KSIZE * KSIZE * DEFAULT_PIX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } convState_t;

    // Row-major 3x3 array to flat vector, element [0][0] in the MSBs.
    function automatic logic [WIN_W-1:0] packWindow(
        input logic [DEFAULT_PIX_W-1:0] win [KSIZE][KSIZE]
    );
        logic [WIN_W-1:0] v;
        v = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                v[(KSIZE*KSIZE-1-(r*KSIZE+c))*DEFAULT_PIX_W +: DEFAULT_PIX_W] = win[r][c];
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two chained IMG_W-deep pixel delay lines; taps give rows r-1 and r-2 at the current column.
module conv_line_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             shiftEn,
    input  logic [PIX_W-1:0] pixel,
    output logic [PIX_W-1:0] tap1,
    output logic [PIX_W-1:0] tap2
);

    logic [PIX_W-1:0] row1 [DEPTH];
    logic [PIX_W-1:0] row2 [DEPTH];

    // Contents are don't-care after reset; the window gating never exposes stale rows.
    always_ff @(posedge clk) begin
        if (shiftEn) begin
            row1[0] <= pixel;
            row2[0] <= row1[DEPTH-1];
            for (int i = 1; i < DEPTH; i++) begin
                row1[i] <= row1[i-1];
                row2[i] <= row2[i-1];
            end
        end
    end

    assign tap1 = row1[DEPTH-1];
    assign tap2 = row2[DEPTH-1];

endmodule

// File: rtl/conv_window_scheduler.sv
// Builds 3x3 windows from a raster pixel stream and presents window/filter pairs
// to the convolution datapath with ready/valid on both sides.
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned PIX_W = DEFAULT_PIX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         filter_load,
    input  logic [KSIZE*KSIZE*PIX_W-1:0] filter_i,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PIX_W-1:0]             pixel_i,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [KSIZE*KSIZE*PIX_W-1:0] window_o,
    output logic [KSIZE*KSIZE*PIX_W-1:0] filter_o,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned NTAP  = KSIZE * KSIZE;

    convState_t       state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [PIX_W-1:0] tap1;
    logic [PIX_W-1:0] tap2;
    logic [PIX_W-1:0] win    [KSIZE][KSIZE-1];
    logic [PIX_W-1:0] newCol [KSIZE];
    logic [NTAP*PIX_W-1:0] nextWin;
    logic accept;
    logic lastCol;
    logic lastPix;
    logic winHit;

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign lastCol  = (col == COL_W'(IMG_W-1));
    assign lastPix  = lastCol && (row == ROW_W'(IMG_H-1));
    assign winHit   = (row >= ROW_W'(KSIZE-1)) && (col >= COL_W'(KSIZE-1));

    conv_line_buffer #(
        .DEPTH(IMG_W),
        .PIX_W(PIX_W)
    ) u_lineBuf (
        .clk    (clk),
        .shiftEn(accept),
        .pixel  (pixel_i),
        .tap1   (tap1),
        .tap2   (tap2)
    );

    // Newest column: oldest row on top, incoming pixel at the bottom.
    always_comb begin
        newCol[0] = tap2;
        newCol[1] = tap1;
        newCol[2] = pixel_i;
        nextWin   = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE-1; c++) begin
                nextWin[(NTAP-1-(r*KSIZE+c))*PIX_W +: PIX_W] = win[r][c];
            end
            nextWin[(NTAP-1-(r*KSIZE+KSIZE-1))*PIX_W +: PIX_W] = newCol[r];
        end
    end

    // Two older window columns; only advances on pixel acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < KSIZE; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= newCol[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            out_valid  <= 1'b0;
            window_o   <= '0;
            filter_o   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // A new window may replace one being handshaken in the same cycle.
            if (accept && winHit) begin
                window_o  <= nextWin;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                if (lastPix) begin
                    row <= '0;
                    col <= '0;
                end else if (lastCol) begin
                    row <= row + 1'b1;
                    col <= '0;
                end else begin
                    col <= col + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (filter_load) begin
                        filter_o <= filter_i;
                    end
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                RUN: begin
                    if (accept && lastPix) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (out_valid && out_ready) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Randomised bench for conv_window_scheduler on a 5x5 image, checked every cycle
// against a frame-level model of which windows must appear and in what order.
module tb_conv_window_scheduler;

    localparam int W     = 5;
    localparam int H     = 5;
    localparam int NPIX  = W * H;
    localparam int NWIN  = (W - 2) * (H - 2);
    localparam int WW    = 72;
    localparam int BUDGET = 3000;

    localparam logic [WW-1:0] F19      = 72'h010203040506070809;
    localparam logic [WW-1:0] WIN_FIRST = 72'h0102030607080B0C0D;
    localparam logic [WW-1:0] WIN_LAST  = 72'h0D0E0F121314171819;
    localparam logic [WW-1:0] WIN_2ND   = 72'h0203040708090C0D0E;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          filter_load;
    logic [WW-1:0] filter_i;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    pixel_i;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] window_o;
    logic [WW-1:0] filter_o;
    logic          busy;
    logic          frame_done;

    conv_window_scheduler #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .filter_load(filter_load),
        .filter_i   (filter_i),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pixel_i    (pixel_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .window_o   (window_o),
        .filter_o   (filter_o),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Model state: frame active, pixels taken, windows produced/consumed.
    logic [7:0]    img [NPIX];
    logic [WW-1:0] filtExp;
    logic          busyExp;
    logic          fdExp;
    logic          expIr;
    int            pixCnt;
    int            winE;
    int            winC;
    int            fdCount;
    int            stallCnt;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Window k covers output position (2 + k/(W-2), 2 + k%(W-2)).
    function automatic logic [WW-1:0] expWin(input int k);
        logic [WW-1:0] v;
        int r;
        int c;
        v = '0;
        r = 2 + k / (W - 2);
        c = 2 + k % (W - 2);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v[(8 - (i * 3 + j)) * 8 +: 8] = img[(r - 2 + i) * W + (c - 2 + j)];
            end
        end
        return v;
    endfunction

    task automatic resetModel();
        busyExp = 1'b0;
        fdExp   = 1'b0;
        pixCnt  = 0;
        winE    = 0;
        winC    = 0;
        filtExp = '0;
    endtask

    // Compare against the model, then advance it to what the next edge must produce.
    always @(negedge clk) begin
        if (!rst) begin
            expIr = busyExp && (pixCnt < NPIX) && (!(winE > winC) || out_ready);
            chk("in_ready", 72'(in_ready), 72'(expIr));
            chk("out_valid", 72'(out_valid), 72'(winE > winC));
            chk("busy", 72'(busy), 72'(busyExp));
            chk("frame_done", 72'(frame_done), 72'(fdExp));
            chk("filter_o", filter_o, filtExp);
            if (winE > winC) chk("window_o", window_o, expWin(winC));
            fdCount = fdCount + int'(frame_done);

            fdExp = 1'b0;
            if (!busyExp) begin
                if (filter_load) filtExp = filter_i;
                if (start) begin
                    busyExp = 1'b1;
                    pixCnt  = 0;
                    winE    = 0;
                    winC    = 0;
                end
            end else begin
                if ((winE > winC) && out_ready) begin
                    winC++;
                    if (winC == NWIN) begin
                        busyExp = 1'b0;
                        fdExp   = 1'b1;
                    end
                end
                if (in_valid && expIr) begin
                    if ((pixCnt / W) >= 2 && (pixCnt % W) >= 2) winE++;
                    pixCnt++;
                end
            end
        end
    end

    // ivMode: 0 always valid, 1 every 3rd cycle, 2 random. orMode: 0 ready, 1 stall 2nd window, 2 random.
    task automatic runFrame(input int ivMode, input int orMode, input logic loadF,
                            input logic [WW-1:0] f, input logic midLoad,
                            input logic startFlush, input int abortAt);
        int  cyc;
        logic done;
        fdCount  = 0;
        stallCnt = 0;
        @(posedge clk); #1;
        start       = 1'b1;
        filter_load = loadF;
        filter_i    = f;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            cyc++;
            start       = 1'b0;
            filter_load = 1'b0;
            if (!busyExp) begin
                done = 1'b1;
            end else if (cyc > BUDGET) begin
                chk("frame_timeout", 72'(cyc), 72'(BUDGET));
                done = 1'b1;
            end else begin
                case (ivMode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (cyc % 3 == 0);
                    default: in_valid = ($urandom_range(0, 3) != 0);
                endcase
                pixel_i = (pixCnt < NPIX) ? img[pixCnt] : 8'($urandom);
                case (orMode)
                    0: out_ready = 1'b1;
                    1: begin
                        if (winC == 1 && winE > winC && stallCnt < 4) begin
                            out_ready = 1'b0;
                            stallCnt++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                    default: out_ready = ($urandom_range(0, 2) != 0);
                endcase
                if (midLoad && pixCnt == 10) begin
                    filter_load = 1'b1;
                    filter_i    = '1;
                end
                if (startFlush && pixCnt == NPIX) start = 1'b1;
                if (orMode == 1 && stallCnt == 2 && !out_ready) begin
                    #1;
                    chk("stall_window", window_o, WIN_2ND);
                    chk("stall_in_ready", 72'(in_ready), 72'(0));
                end
                if (abortAt > 0 && pixCnt == abortAt) begin
                    in_valid = 1'b0;
                    #1 rst = 1'b1;
                    #1;
                    chk("rst_out_valid", 72'(out_valid), 72'(0));
                    chk("rst_busy", 72'(busy), 72'(0));
                    chk("rst_filter_o", filter_o, 72'(0));
                    chk("rst_in_ready", 72'(in_ready), 72'(0));
                    resetModel();
                    #1 rst = 1'b0;
                    done = 1'b1;
                end
            end
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        if (abortAt == 0) begin
            @(negedge clk); #1;
            chk("frame_done_count", 72'(fdCount), 72'(1));
        end
    endtask

    task automatic setRamp();
        for (int i = 0; i < NPIX; i++) img[i] = 8'(i + 1);
    endtask

    task automatic setRandom();
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
    endtask

    initial begin
        logic [WW-1:0] rf;
        rst         = 1'b1;
        start       = 1'b0;
        filter_load = 1'b0;
        filter_i    = '0;
        in_valid    = 1'b0;
        pixel_i     = '0;
        out_ready   = 1'b1;
        fdCount     = 0;
        resetModel();
        #12;
        chk("reset_out_valid", 72'(out_valid), 72'(0));
        chk("reset_busy", 72'(busy), 72'(0));
        chk("reset_frame_done", 72'(frame_done), 72'(0));
        chk("reset_window_o", window_o, 72'(0));
        chk("reset_filter_o", filter_o, 72'(0));
        chk("reset_in_ready", 72'(in_ready), 72'(0));
        rst = 1'b0;

        setRamp();
        chk("model_first_win", expWin(0), WIN_FIRST);
        chk("model_last_win", expWin(NWIN - 1), WIN_LAST);
        runFrame(0, 0, 1'b1, F19, 1'b0, 1'b0, 0);
        chk("filter_after_frame", filter_o, F19);
        chk("busy_after_frame", 72'(busy), 72'(0));

        runFrame(0, 1, 1'b0, '0, 1'b0, 1'b0, 0);
        runFrame(1, 0, 1'b0, '0, 1'b0, 1'b0, 0);
        runFrame(2, 2, 1'b0, '0, 1'b1, 1'b0, 0);
        chk("filter_ignored_in_run", filter_o, F19);

        @(posedge clk); #1;
        filter_load = 1'b1;
        filter_i    = '1;
        @(posedge clk); #1;
        filter_load = 1'b0;
        chk("filter_load_idle", filter_o, {WW{1'b1}});

        setRamp();
        runFrame(0, 0, 1'b1, F19, 1'b0, 1'b0, 12);
        chk("post_reset_filter", filter_o, 72'(0));
        setRandom();
        rf = {8'($urandom), 32'($urandom), 32'($urandom)};
        runFrame(2, 2, 1'b1, rf, 1'b0, 1'b0, 0);

        runFrame(2, 2, 1'b0, '0, 1'b0, 1'b1, 0);
        chk("idle_after_flush_start", 72'(busy), 72'(0));

        for (int n = 0; n < 4; n++) begin
            setRandom();
            rf = {8'($urandom), 32'($urandom), 32'($urandom)};
            runFrame(2, 2, 1'($urandom_range(0, 1)), rf, 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_window_scheduler.md
Name: conv_window_scheduler

Overview:
- Sequencing controller in front of the combinational 3x3 convolution datapath (72-bit window, 72-bit filter, 8-bit result).
- Accepts a raster-order pixel stream, builds 3x3 windows with two line buffers, and holds the filter coefficients.
- Presents window/filter pairs for every valid (non-border) output position, with ready/valid flow control on both sides.
- The datapath is instantiated by the parent and is not part of this block.

Parameters:
- IMG_W, 8, image width in pixels (>=3)
- IMG_H, 8, image height in pixels (>=3)
- PIX_W, 8, bits per pixel and per coefficient

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; honoured only in IDLE
- filter_load  in  1  capture filter_i; honoured only in IDLE
- filter_i  in  9*PIX_W  coefficients, element 0 (top-left) in MSBs, row-major
- in_valid  in  1  pixel_i valid
- in_ready  out  1  block accepts pixel this cycle
- pixel_i  in  PIX_W  raster-order pixel
- out_valid  out  1  window_o/filter_o valid
- out_ready  in  1  downstream accepts window
- window_o  out  9*PIX_W  3x3 window, top-left in MSBs, row-major (same packing as filter)
- filter_o  out  9*PIX_W  registered filter
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after the last window handshake

Behaviour:
- Reset values (async): state=IDLE, in_ready=0, out_valid=0, window_o=0, filter_o=0, busy=0, frame_done=0, row/col counters=0. Line buffer contents are don't-care.
- States: IDLE, RUN, FLUSH.
  - IDLE: start -> RUN with row=col=0. filter_load (same cycle or earlier) updates filter_o on the next edge. If start and filter_load coincide, the new filter is used for the frame.
  - RUN -> FLUSH on acceptance of pixel (IMG_H-1, IMG_W-1).
  - FLUSH -> IDLE when the final window handshakes (out_valid & out_ready). frame_done=1 for exactly that following cycle.
- in_ready = (state==RUN) && (!out_valid || out_ready). It is 0 in IDLE and FLUSH.
- A pixel is accepted on in_valid & in_ready. On acceptance, col increments and wraps at IMG_W-1 to 0, with row incrementing.
- Line buffers: two IMG_W-deep PIX_W shift rows holding rows r-1 and r-2. Each accepted pixel shifts into row r and pushes the displaced pixel through.
- The window column shift register (3x3) updates only on acceptance.
- Accepting pixel (r,c) with r>=2 and c>=2 loads window_o with rows r-2..r, cols c-2..c, and sets out_valid on the next edge.
  - Latency: 1 cycle, pixel acceptance to out_valid.
  - Accepted pixels with r<2 or c<2 produce no output.
- out_valid stays high and window_o stays stable until out_ready. It clears on handshake unless a new window loads the same cycle; that is allowed because in_ready includes out_ready.
- Windows per frame: exactly (IMG_W-2)*(IMG_H-2).
- filter_load while busy is ignored; filter_o stays constant for the whole frame.
- start while busy is ignored.
- Column wrap: windows never straddle rows; the c>=2 gate enforces this.
- Counters: $clog2(IMG_W) and $clog2(IMG_H) bits, no overflow beyond IMG bounds.
- Reset mid-frame: returns to IDLE immediately, drops out_valid, clears filter_o. The next frame requires filter_load and start again.

Decomposition:
- Package conv_pkg:
  - PIX_W default
  - KSIZE=3
  - WIN_W=KSIZE*KSIZE*PIX_W
  - state enum typedef {IDLE, RUN, FLUSH}
  - a function packing a 3x3 array into the 72-bit vector (top-left MSB)
- One sub-module, conv_line_buffer: parameterised depth IMG_W, shift-enable, PIX_W data, two tap outputs (row-1 and row-2 at the current column).

Test Plan:
- Filter 1..9 loaded, 5x5 frame with pixels 1..25, out_ready=1 -> 9 windows. First window_o = {1,2,3,6,7,8,11,12,13}, last = {13,14,15,18,19,20,23,24,25], filter_o = {1..9}, frame_done pulses once, busy falls.
- Same frame, out_ready held 0 for 4 cycles at the 2nd window -> in_ready=0, window_o stable at {2,3,4,7,8,9,12,13,14}, no pixels lost, 9 windows total.
- in_valid gaps (pixel every 3rd cycle) -> identical window sequence to the first scenario; windows are emitted only at c>=2, r>=2.
- filter_load with filter_i all 0xFF during RUN -> ignored, filter_o remains {1..9}. The same load in IDLE -> filter_o all 0xFF next cycle.
- rst asserted after 12 pixels -> out_valid=0, busy=0, filter_o=0 asynchronously. A new start with a reloaded filter on a fresh 5x5 frame -> correct 9 windows.
- start pulsed during FLUSH -> ignored, frame_done once, block returns to IDLE.
